// File: rtl/complex_mult_pipe.sv
// Pipelined signed complex multiplier, p = a*b, 16-bit I/Q in, 32-bit I/Q out.
// A strobe rides a matching delay line so validity tracks data through stalls.

module cmp_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("cmp_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (enable) begin
            stage_d[0] = data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

module complex_mult_pipe #(
    parameter int LATENCY   = 4,
    parameter int STB_WIDTH = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] a_i,
    input  logic [15:0] a_q,
    input  logic [15:0] b_i,
    input  logic [15:0] b_q,
    input  logic        input_strobe,
    output logic [31:0] p_i,
    output logic [31:0] p_q,
    output logic        output_strobe
);

    // S1: operand registers
    logic signed [15:0] a_i_q, a_q_q, b_i_q, b_q_q;
    logic signed [15:0] a_i_d, a_q_d, b_i_d, b_q_d;
    // S2: partial products
    logic signed [31:0] ii_q, qq_q, iq_q, qi_q;
    logic signed [31:0] ii_d, qq_d, iq_d, qi_d;
    // S3: combine, S4: output
    logic [31:0] re_q, im_q, re_d, im_d;
    logic [31:0] out_i_q, out_q_q, out_i_d, out_q_d;

    logic [STB_WIDTH-1:0] stb_in;
    logic [STB_WIDTH-1:0] stb_out;

    // Data is computed every enabled cycle; the strobe alone marks validity.
    always_comb begin
        a_i_d   = a_i_q;
        a_q_d   = a_q_q;
        b_i_d   = b_i_q;
        b_q_d   = b_q_q;
        ii_d    = ii_q;
        qq_d    = qq_q;
        iq_d    = iq_q;
        qi_d    = qi_q;
        re_d    = re_q;
        im_d    = im_q;
        out_i_d = out_i_q;
        out_q_d = out_q_q;
        if (enable) begin
            a_i_d   = $signed(a_i);
            a_q_d   = $signed(a_q);
            b_i_d   = $signed(b_i);
            b_q_d   = $signed(b_q);
            ii_d    = a_i_q * b_i_q;
            qq_d    = a_q_q * b_q_q;
            iq_d    = a_i_q * b_q_q;
            qi_d    = a_q_q * b_i_q;
            // Modulo 2^32: only the all -32768 case wraps (p_q = 2^31).
            re_d    = ii_q - qq_q;
            im_d    = iq_q + qi_q;
            out_i_d = re_q;
            out_q_d = im_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_i_q   <= '0;
            a_q_q   <= '0;
            b_i_q   <= '0;
            b_q_q   <= '0;
            ii_q    <= '0;
            qq_q    <= '0;
            iq_q    <= '0;
            qi_q    <= '0;
            re_q    <= '0;
            im_q    <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
        end else begin
            a_i_q   <= a_i_d;
            a_q_q   <= a_q_d;
            b_i_q   <= b_i_d;
            b_q_q   <= b_q_d;
            ii_q    <= ii_d;
            qq_q    <= qq_d;
            iq_q    <= iq_d;
            qi_q    <= qi_d;
            re_q    <= re_d;
            im_q    <= im_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
        end
    end

    assign stb_in = STB_WIDTH'(input_strobe);

    cmp_delay_line #(
        .WIDTH (STB_WIDTH),
        .DEPTH (LATENCY)
    ) u_stb_delay (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .data_in  (stb_in),
        .data_out (stb_out)
    );

    assign p_i           = out_i_q;
    assign p_q           = out_q_q;
    assign output_strobe = stb_out[0];

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed bench for complex_mult_pipe: stimulus pushes expected products and
// their due enabled-edge count; a negedge monitor pops and compares.

module tb_complex_mult_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] a_i, a_q, b_i, b_q;
    logic        input_strobe;
    logic [31:0] p_i, p_q;
    logic        output_strobe;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;
    bit last_en = 1'b0;

    logic [63:0] exp_q[$];
    int          due_q[$];
    logic [31:0] last_exp_i = '0;
    logic [31:0] last_exp_q = '0;
    logic [63:0] mon_e;
    int          mon_d;

    complex_mult_pipe #(.LATENCY(4), .STB_WIDTH(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .a_i           (a_i),
        .a_q           (a_q),
        .b_i           (b_i),
        .b_q           (b_q),
        .input_strobe  (input_strobe),
        .p_i           (p_i),
        .p_q           (p_q),
        .output_strobe (output_strobe)
    );

    // clock/reset block
    always #5 clock = ~clock;

    always @(posedge clock) begin
        last_en <= enable && !reset;
        if (enable && !reset) en_cnt <= en_cnt + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)",
                     name, $signed(act), act, $signed(req), req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_inputs(input logic stb);
        a_i = 16'($urandom_range(0, 65535));
        a_q = 16'($urandom_range(0, 65535));
        b_i = 16'($urandom_range(0, 65535));
        b_q = 16'($urandom_range(0, 65535));
        input_strobe = stb;
    endtask

    // Caller guarantees enable=1 and reset=0 for the next edge.
    task automatic drive(input logic [15:0] ai, input logic [15:0] aq,
                         input logic [15:0] bi, input logic [15:0] bq,
                         input logic [31:0] ei, input logic [31:0] eq);
        a_i = ai; a_q = aq; b_i = bi; b_q = bq;
        input_strobe = 1'b1;
        exp_q.push_back({ei, eq});
        due_q.push_back(en_cnt + 4);
        tick();
    endtask

    task automatic idle_drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            rand_inputs(1'b0);
            tick();
        end
        rand_inputs(1'b0);
        repeat (3) tick();
        check32("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard monitor: only fresh outputs (after an enabled edge) are consumed
    always @(negedge clock) begin
        if (!reset && last_en && output_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got output_strobe=1 p_i=%0d p_q=%0d, required no strobe",
                         $signed(p_i), $signed(p_q));
            end else begin
                mon_e = exp_q.pop_front();
                mon_d = due_q.pop_front();
                check32("p_i", p_i, mon_e[63:32]);
                check32("p_q", p_q, mon_e[31:0]);
                check32("latency_enabled_edges", 32'(en_cnt), 32'(mon_d));
                last_exp_i = mon_e[63:32];
                last_exp_q = mon_e[31:0];
            end
        end
    end

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        rand_inputs(1'b1);

        // reset held 3 cycles with live strobes
        repeat (3) begin
            rand_inputs(1'b1);
            tick();
            check32("reset_p_i", p_i, 32'd0);
            check32("reset_p_q", p_q, 32'd0);
            check32("reset_strobe", 32'(output_strobe), 32'd0);
        end
        reset = 1'b0;

        // basic product: (3+4j)(5-2j) = 23+14j
        drive(16'd3, 16'd4, 16'd5, 16'hfffe, 32'd23, 32'd14);
        idle_drain();

        // extremes, including the single wrapping case
        drive(16'h8000, 16'd0, 16'h8000, 16'd0, 32'd1073741824, 32'd0);
        drive(16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'd0, 32'h80000000);
        idle_drain();

        // streaming (k - kj)(2 + j) = 3k - kj, with a 2-cycle stall after k=6
        for (int k = 1; k <= 8; k++) begin
            drive(16'(k), 16'(-k), 16'd2, 16'd1, 32'(3 * k), 32'(-k));
            if (k == 6) begin
                enable = 1'b0;
                repeat (2) begin
                    rand_inputs(1'b1);
                    tick();
                    check32("stall_hold_p_i", p_i, last_exp_i);
                    check32("stall_hold_p_q", p_q, last_exp_q);
                    check32("stall_hold_strobe", 32'(output_strobe), 32'd1);
                end
                enable = 1'b1;
            end
        end
        idle_drain();

        // reset (with enable low) while 3 samples are in flight
        drive(16'd100, 16'hffce, 16'd7, 16'd3, 32'd850, 32'hffffffce);
        drive(16'd1, 16'd1, 16'd1, 16'd1, 32'd0, 32'd2);
        drive(16'd9, 16'd0, 16'd9, 16'd0, 32'd81, 32'd0);
        reset = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        due_q.delete();
        rand_inputs(1'b1);
        tick();
        check32("midreset_p_i", p_i, 32'd0);
        check32("midreset_p_q", p_q, 32'd0);
        check32("midreset_strobe", 32'(output_strobe), 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        // (-1200 + 345j)(-7 + 11j) = 4605 - 15615j
        drive(16'hfb50, 16'd345, 16'hfff9, 16'd11, 32'd4605, 32'hffffc301);
        idle_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/complex_mult_pipe.md
# complex_mult_pipe

Pipelined signed complex multiplier for the OFDM receive datapath. It computes p = a·b on 16-bit I/Q operands and delivers full-precision 32-bit I/Q products, with a strobe that travels alongside the data. It serves phase rotation (input sample × rotation-LUT phasor), correlation and equalisation stages. A generic internal delay line carries the strobe and stalls together with the arithmetic pipeline.

## Interface
Parameters:
- LATENCY, 4, enabled cycles from input sample to output. Fixed at 4 in this block; any other value is unsupported.
- STB_WIDTH, 1, width of the delay line carrying the strobe.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high; clock clock
- enable  in  1  pipeline advance qualifier; when low, every register holds
- a_i, a_q  in  16 each  operand A, signed two's complement
- b_i, b_q  in  16 each  operand B, signed two's complement
- input_strobe  in  1  marks a valid operand pair on this edge
- p_i  out  32  signed real part, a_i·b_i − a_q·b_q
- p_q  out  32  signed imaginary part, a_i·b_q + a_q·b_i
- output_strobe  out  1  marks a valid p_i/p_q

## Operation
- Four-stage pipeline:
  - S1 registers a_i, a_q, b_i, b_q.
  - S2 registers the four 32-bit signed products a_i·b_i, a_q·b_q, a_i·b_q, a_q·b_i.
  - S3 registers the difference and the sum.
  - S4 is the output register that drives p_i and p_q.
- Arithmetic:
  - Products are full signed 16×16→32.
  - The add and subtract are performed modulo 2^32; overflow wraps with no saturation.
  - The only wrapping case is a_i=a_q=b_i=b_q=−32768, whose p_q = 2^31 wraps to −2147483648.
- Data is computed every enabled cycle regardless of input_strobe. The strobe only qualifies validity, so downstream logic must ignore p_* when output_strobe is low.
- Strobe path:
  - A generic delay line (width STB_WIDTH, depth LATENCY) built as a shift register of LATENCY registers.
  - Its shift is gated by the same enable as the data pipeline.
  - Its reset value is 0.
- The delay line is a reusable submodule parameterised by data width and depth. Depth 0 is illegal.
- Consumers rescale the result by taking a bit slice of p_* (for example, bits [S+15:S] for a LUT scaled by 2^S). The block itself never truncates.

## Timing
- Reset behaviour:
  - Reset is synchronous and active-high, and it overrides enable.
  - On the first edge with reset high, all pipeline registers and every delay-line stage clear to 0.
  - p_i=0, p_q=0 and output_strobe=0 from that edge until new data propagates.
- Latency:
  - Operands sampled on enabled edge n appear on p_i/p_q, with output_strobe=1, after enabled edge n+3.
  - The result is therefore valid during the cycle after the 4th enabled edge counting edge n as the 1st.
  - Measured in clocks with enable held high, an input presented in cycle t yields its output in cycle t+4.
- Throughput: one operand pair per enabled cycle. Back-to-back strobes produce back-to-back output strobes, in order.
- Stall:
  - With enable=0, all registers, outputs and output_strobe hold their values. A high output_strobe remains high through the stall.
  - Inputs presented during a stall are ignored.
  - Latency in clocks grows by exactly the number of stalled cycles.
- Reset mid-stream: in-flight samples are discarded. No output_strobe may emerge for samples accepted before reset.
- Reset and enable low together: reset still clears everything.

## Test plan
- Reset: hold reset 3 cycles with random inputs and input_strobe=1 -> p_i=0, p_q=0, output_strobe=0; after release, first strobe appears exactly 4 cycles after the first input strobe.
- Basic product: a=(3,4), b=(5,−2), strobe at cycle t -> p_i=23, p_q=14, output_strobe=1 at t+4 only.
- Extremes: a=(−32768,0), b=(−32768,0) -> p_i=1073741824, p_q=0; then a=(−32768,−32768), b=(−32768,−32768) -> p_i=0, p_q=−2147483648 (wrap).
- Streaming: strobe every cycle with a=(k,−k), b=(2,1) for k=1..8 -> outputs in order, p_i=3k, p_q=−k, continuous output_strobe.
- Stall: during a stream, drop enable for 2 cycles -> outputs and strobe frozen; total latency for affected samples = 6 clocks; no sample lost or duplicated.
- Reset mid-stream: assert reset one cycle while 3 samples are in flight -> no output_strobe for those samples; a new sample after reset emerges 4 enabled cycles later, correct.
